conv_map_writer: RTL and testbench

//  Sink end of the conv-layer stream: takes one conv output pixel per in_valid beat (conv_num channels),

---
 rtl/cnn_pkg.sv | 36 +++
 rtl/fmap_bank_ram.sv | 44 ++++
 rtl/conv_map_writer.sv | 177 +++++++++++++++++
 tb/tb_conv_map_writer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the conv-layer sink: FSM encoding and requantization helpers.
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_t;

    function automatic logic signed [63:0] sat_max(input int b);
        return (64'sd1 <<< (b - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int b);
        return -(64'sd1 <<< (b - 1));
    endfunction

    // Clipping is decided on the whole shifted accumulator so large values saturate instead of wrapping.
    function automatic logic signed [63:0] quantize(input logic signed [63:0] acc,
                                                    input int b,
                                                    input int shift,
                                                    input logic relu);
        logic signed [63:0] q;
        q = acc >>> shift;
        if (q > sat_max(b)) begin
            q = sat_max(b);
        end else if (q < sat_min(b)) begin
            q = sat_min(b);
        end
        if (relu && (q < 64'sd0)) begin
            q = 64'sd0;
        end
        return q;
    endfunction

endpackage

// File: rtl/fmap_bank_ram.sv
// One channel's feature-map bank: single write port, single read port, read-first, registered read data.
module fmap_bank_ram #(
    parameter int bits   = 16,
    parameter int addr_2 = 11
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [addr_2-1:0] wr_addr,
    input  logic [bits-1:0]   wr_data,
    input  logic              rd_en,
    input  logic [addr_2-1:0] rd_addr,
    output logic [bits-1:0]   rd_data
);

    logic [bits-1:0] mem [2**addr_2];
    logic [bits-1:0] rd_data_d;
    logic [bits-1:0] rd_data_q;

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read samples the array before this edge's write lands, giving old data on a collision.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/conv_map_writer.sv
// Sink of the conv stream: requantizes each pixel beat and writes it row-major into per-channel banks.
module conv_map_writer
    import cnn_pkg::*;
#(
    parameter int bits       = 16,
    parameter int acc_bits   = 32,
    parameter int conv_num   = 4,
    parameter int out_length = 24,
    parameter int out_height = 62,
    parameter int addr_2     = 11,
    parameter int frac_shift = 8,
    parameter bit relu_en    = 1'b1
) (
    input  logic                         clk_in,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic [conv_num*acc_bits-1:0] in_data,
    input  logic                         rd_en,
    input  logic [addr_2-1:0]            rd_addr,
    output logic [conv_num*bits-1:0]     rd_data,
    output logic                         busy,
    output logic                         done,
    output logic                         err_extra
);

    localparam int COL_W = $clog2(out_length);
    localparam int ROW_W = $clog2(out_height);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(out_length - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(out_height - 1);

    wr_state_t                state_d, state_q;
    logic [COL_W-1:0]         col_d, col_q;
    logic [ROW_W-1:0]         row_d, row_q;
    logic [addr_2-1:0]        addr_d, addr_q;
    logic                     draining_d, draining_q;
    logic                     s1_valid_d, s1_valid_q;
    logic                     s1_last_d, s1_last_q;
    logic [addr_2-1:0]        s1_addr_d, s1_addr_q;
    logic [conv_num*bits-1:0] s1_data_d, s1_data_q;
    logic                     last_commit_d, last_commit_q;
    logic                     busy_d, busy_q;
    logic                     done_d, done_q;
    logic                     err_d, err_q;
    logic [conv_num*bits-1:0] q_data;

    always_comb begin
        q_data = '0;
        for (int c = 0; c < conv_num; c++) begin
            q_data[c*bits +: bits] = bits'(quantize(64'(signed'(in_data[c*acc_bits +: acc_bits])),
                                                    bits, frac_shift, relu_en));
        end
    end

    // After the final beat the FSM stays in WRITE while it drains, so done only rises once the last write is in the banks.
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        addr_d        = addr_q;
        draining_d    = draining_q;
        s1_valid_d    = 1'b0;
        s1_last_d     = 1'b0;
        s1_addr_d     = s1_addr_q;
        s1_data_d     = s1_data_q;
        last_commit_d = s1_valid_q && s1_last_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_WRITE;
                    col_d      = '0;
                    row_d      = '0;
                    addr_d     = '0;
                    draining_d = 1'b0;
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                end
                if (in_valid) begin
                    err_d = 1'b1;
                end
            end
            ST_WRITE: begin
                if (in_valid && !draining_q) begin
                    s1_valid_d = 1'b1;
                    s1_addr_d  = addr_q;
                    s1_data_d  = q_data;
                    addr_d     = addr_q + 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            draining_d = 1'b1;
                            s1_last_d  = 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end else if (in_valid) begin
                    err_d = 1'b1;
                end
                if (last_commit_q) begin
                    state_d    = ST_DONE;
                    draining_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (in_valid) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            col_q         <= '0;
            row_q         <= '0;
            addr_q        <= '0;
            draining_q    <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_last_q     <= 1'b0;
            s1_addr_q     <= '0;
            s1_data_q     <= '0;
            last_commit_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            addr_q        <= addr_d;
            draining_q    <= draining_d;
            s1_valid_q    <= s1_valid_d;
            s1_last_q     <= s1_last_d;
            s1_addr_q     <= s1_addr_d;
            s1_data_q     <= s1_data_d;
            last_commit_q <= last_commit_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    for (genvar c = 0; c < conv_num; c++) begin : g_bank
        fmap_bank_ram #(
            .bits   (bits),
            .addr_2 (addr_2)
        ) u_bank (
            .clk_in  (clk_in),
            .rst_n   (rst_n),
            .wr_en   (s1_valid_q),
            .wr_addr (s1_addr_q),
            .wr_data (s1_data_q[c*bits +: bits]),
            .rd_en   (rd_en),
            .rd_addr (rd_addr),
            .rd_data (rd_data[c*bits +: bits])
        );
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err_extra = err_q;

endmodule

// File: tb/tb_conv_map_writer.sv
// Scoreboard bench for conv_map_writer: two instances (ReLU on / off) share stimulus, a monitor checks reads, done and status.
module tb_conv_map_writer;

    localparam int FRAME = 24 * 62;

    logic         clk_in   = 1'b0;
    logic         rst_n    = 1'b0;
    logic         start    = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] in_data  = '0;
    logic         rd_en    = 1'b0;
    logic [10:0]  rd_addr  = '0;
    logic [63:0]  rd_data_r, rd_data_l;
    logic         busy_r, done_r, err_r;
    logic         busy_l, done_l, err_l;

    typedef struct {
        string       name;
        logic [63:0] exp_r;
        logic [63:0] exp_l;
    } rd_exp_t;

    typedef struct {
        string name;
        logic  busy;
        logic  err;
        logic  chk_rd;
    } st_exp_t;

    rd_exp_t rd_q[$];
    st_exp_t st_q[$];
    int      done_q[$];
    int      n_checks   = 0;
    int      n_fail     = 0;
    int      cyc        = 0;
    logic    rd_seen    = 1'b0;
    logic    status_req = 1'b0;

    conv_map_writer #(.relu_en(1'b1)) dut_relu (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data_r),
        .busy      (busy_r),
        .done      (done_r),
        .err_extra (err_r)
    );

    conv_map_writer #(.relu_en(1'b0)) dut_lin (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data_l),
        .busy      (busy_l),
        .done      (done_l),
        .err_extra (err_l)
    );

    initial forever #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: cycle %0d reached, required test end before cycle 50000", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic check_empty(input string nm, input int left);
        n_checks++;
        if (left != 0) begin
            n_fail++;
            $display("[TB] FAIL %s: %0d expectations left, expected 0", nm, left);
        end
    endtask

    always @(posedge clk_in) begin
        cyc     <= cyc + 1;
        rd_seen <= rd_en;
    end

    // Monitor: everything the DUTs present is compared here against what the stimulus queued.
    always @(negedge clk_in) begin
        rd_exp_t re;
        st_exp_t se;
        int      exp_cyc;
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                check_empty("rd_unexpected", 1);
            end else begin
                re = rd_q.pop_front();
                check64({re.name, "/relu"}, rd_data_r, re.exp_r);
                check64({re.name, "/lin"}, rd_data_l, re.exp_l);
            end
        end
        if (done_r || done_l) begin
            n_checks++;
            if (done_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL done_unexpected: cycle %0d done_relu=%0b done_lin=%0b, expected no done",
                         cyc, done_r, done_l);
            end else begin
                exp_cyc = done_q.pop_front();
                if (!(done_r && done_l && cyc == exp_cyc)) begin
                    n_fail++;
                    $display("[TB] FAIL done_timing: cycle %0d done_relu=%0b done_lin=%0b, expected both at cycle %0d",
                             cyc, done_r, done_l, exp_cyc);
                end
            end
        end
        if (status_req && st_q.size() != 0) begin
            se = st_q.pop_front();
            check64({se.name, "/busy"}, {62'd0, busy_r, busy_l}, {62'd0, se.busy, se.busy});
            check64({se.name, "/done"}, {62'd0, done_r, done_l}, 64'd0);
            check64({se.name, "/err"},  {62'd0, err_r, err_l},   {62'd0, se.err, se.err});
            if (se.chk_rd) begin
                check64({se.name, "/rd_relu"}, rd_data_r, 64'd0);
                check64({se.name, "/rd_lin"},  rd_data_l, 64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic apply_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    function automatic logic [127:0] beat_data(input int mode, input int a);
        logic [127:0] d;
        int           v;
        for (int c = 0; c < 4; c++) begin
            v = (mode == 1) ? (32'h7000 + c) : (a * 4 + c);
            d[c*32 +: 32] = 32'(v << 8);
        end
        if (mode == 2 && a == 0)
            d = {32'hFFFFFE00, 32'h00012345, 32'h80000000, 32'h7FFFFF00};
        if (mode == 2 && a == FRAME - 1)
            d = {32'h00800000, 32'h00007FFF, 32'hFFFFFFFF, 32'h7FFFFFFF};
        return d;
    endfunction

    function automatic logic [63:0] std_word(input int a);
        logic [63:0] w;
        for (int c = 0; c < 4; c++) w[c*16 +: 16] = 16'(a * 4 + c);
        return w;
    endfunction

    // Drives n_beats accepted beats; the final beat of a full frame queues done two edges after it is sampled.
    task automatic apply_frame(input int mode, input bit gaps, input int n_beats);
        int a = 0;
        while (a < n_beats) begin
            if (gaps && $urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                in_valid = 1'b1;
                in_data  = beat_data(mode, a);
                if (a == FRAME - 1) done_q.push_back(cyc + 3);
                a++;
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic apply_read(input int a, input logic [63:0] er, input logic [63:0] el);
        rd_exp_t e;
        e.name  = $sformatf("rd[%0d]", a);
        e.exp_r = er;
        e.exp_l = el;
        rd_q.push_back(e);
        rd_en   = 1'b1;
        rd_addr = 11'(a);
        step();
        rd_en = 1'b0;
    endtask

    task automatic apply_read_frame();
        for (int a = 0; a < FRAME; a++) apply_read(a, std_word(a), std_word(a));
    endtask

    task automatic check_status(input string nm, input logic b, input logic e, input logic chk_rd);
        st_exp_t s;
        s.name   = nm;
        s.busy   = b;
        s.err    = e;
        s.chk_rd = chk_rd;
        st_q.push_back(s);
        status_req = 1'b1;
        step();
        status_req = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        rst_n = 1'b1;
        check_status("reset", 1'b0, 1'b0, 1'b1);

        apply_start();
        check_status("busy_after_start", 1'b1, 1'b0, 1'b0);
        apply_frame(0, 1'b0, FRAME);
        repeat (4) step();
        apply_read_frame();

        apply_start();
        apply_frame(2, 1'b0, FRAME);
        repeat (4) step();
        apply_read(0, 64'h0000_0123_0000_7FFF, 64'hFFFE_0123_8000_7FFF);
        apply_read(1, std_word(1), std_word(1));
        apply_read(FRAME - 1, 64'h7FFF_007F_0000_7FFF, 64'h7FFF_007F_FFFF_7FFF);

        apply_start();
        apply_frame(0, 1'b1, FRAME);
        repeat (4) step();
        apply_read_frame();

        in_valid = 1'b1;
        in_data  = beat_data(1, 0);
        step();
        in_valid = 1'b0;
        check_status("err_after_idle_beat", 1'b0, 1'b1, 1'b0);
        apply_read(0, std_word(0), std_word(0));
        apply_start();
        check_status("start_clears_err", 1'b1, 1'b0, 1'b0);

        apply_frame(1, 1'b0, 500);
        rst_n = 1'b0;
        step();
        check_status("abort_in_reset", 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        step();
        check_status("after_abort", 1'b0, 1'b0, 1'b1);
        apply_read(0, 64'h7003_7002_7001_7000, 64'h7003_7002_7001_7000);
        apply_read(1000, std_word(1000), std_word(1000));
        apply_start();
        apply_frame(0, 1'b0, FRAME);
        repeat (4) step();
        apply_read_frame();

        repeat (4) step();
        check_empty("done_pending", done_q.size());
        check_empty("rd_pending", rd_q.size());
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
